// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction prefetch FIFO between core fetch port and memory.
// Ports: clk/reset(n), core PC in, instr data/response out, mem req/ack.
module instruction_prefetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_address,
  output logic [31:0] instruction_data,
  output logic        instruction_response,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fifo_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [31:0]   head_q;
  logic [31:0]   head_d;
  logic          discard_q;
  logic          discard_d;
  logic          req_d;
  logic [31:0]   addr_d;

  logic empty;
  logic hold;
  logic advance;
  logic redirect;
  logic complete;
  logic drop;
  logic enq;

  // mem_req doubles as the pending flag: it is held until the ack.
  always_comb begin
    empty    = (count_q == '0);
    hold     = (instruction_address == head_q);
    advance  = !hold && !empty &&
               (instruction_address == head_q + 32'd4);
    redirect = !hold && !advance;
    complete = mem_req && mem_ack;
    drop     = complete && (discard_q || redirect);
    enq      = complete && !drop;
    wr_ptr   = rd_ptr_q + count_q[PW-1:0];
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    discard_d = discard_q;
    if (redirect) begin
      count_d = '0;
      head_d  = instruction_address;
    end else begin
      count_d = count_q + CW'(enq) - CW'(advance);
      if (advance) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        head_d   = head_q + 32'd4;
      end
    end
    if (complete) begin
      discard_d = 1'b0;
    end else if (redirect && mem_req) begin
      discard_d = 1'b1;
    end
  end

  // An outstanding request is never retracted; a new one is issued
  // only once nothing is in flight, so discard is clear by then.
  always_comb begin
    if (mem_req && !mem_ack) begin
      req_d  = 1'b1;
      addr_d = mem_addr;
    end else begin
      req_d  = (count_d < CW'(DEPTH));
      addr_d = head_d + (32'(count_d) << 2);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= BOOT_ADDRESS;
      discard_q <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= BOOT_ADDRESS;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      discard_q <= discard_d;
      mem_req   <= req_d;
      mem_addr  <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_q[wr_ptr] <= mem_rdata;
    end
  end

  always_comb begin
    instruction_response = !empty && hold;
    instruction_data     = empty ? 32'd0 : fifo_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count_q <= CW'(DEPTH));
      assert (!(enq && !advance && !redirect &&
                count_q == CW'(DEPTH)));
    end
  end

endmodule
